// File: rtl/key_pkg.sv
// Shared constants for the hex key-entry sequencer: FSM state encoding and digit width.
package key_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

endpackage

// File: rtl/key_entry_ctrl.sv
// Collects DIGITS hex key strobes MSB-first into one word for the CPU IN port.
// Handshake: data_valid_o rises with a stable data_o; the word is consumed on the cycle ack_i=1 is sampled.
module key_entry_ctrl
  import key_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int TIMEOUT_CYC = 0,
  localparam int W          = DIGIT_W * DIGITS
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               key_valid_i,
  input  logic [DIGIT_W-1:0] key_num_i,
  input  logic               req_i,
  input  logic               ack_i,
  output logic [W-1:0]       data_o,
  output logic               data_valid_o,
  output logic               busy_o,
  output logic [3:0]         digit_cnt_o,
  output logic [W-1:0]       entry_o,
  output logic               timeout_o,
  output logic [1:0]         state_o
);

  localparam int IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [IDLE_W-1:0] TO_LAST  = IDLE_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [IDLE_W-1:0] TO_LIMIT = IDLE_W'(TIMEOUT_CYC);
  localparam logic [3:0] LAST_CNT = 4'(DIGITS - 1);
  localparam logic [3:0] MAX_CNT  = 4'(DIGITS);

  logic [1:0]        state_q, state_d;
  logic              key_prev_q;
  logic [W-1:0]      entry_q, entry_d;
  logic [W-1:0]      data_q, data_d;
  logic [3:0]        digit_cnt_q, digit_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              data_valid_q, data_valid_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;

  logic              key_stb;
  logic              last_digit;
  logic              expire;
  logic [W-1:0]      entry_shift;

  assign key_stb    = key_valid_i & ~key_prev_q;
  assign last_digit = (digit_cnt_q == LAST_CNT);
  // A strobe in the expiring cycle keeps the entry alive.
  assign expire     = (TIMEOUT_CYC > 0) && !key_stb && (idle_cnt_q == TO_LAST);

  generate
    if (DIGITS == 1) begin : g_single
      assign entry_shift = key_num_i;
    end else begin : g_multi
      assign entry_shift = {entry_q[W-DIGIT_W-1:0], key_num_i};
    end
  endgenerate

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      key_prev_q   <= 1'b0;
      entry_q      <= '0;
      data_q       <= '0;
      digit_cnt_q  <= '0;
      idle_cnt_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_prev_q   <= key_valid_i;
      entry_q      <= entry_d;
      data_q       <= data_d;
      digit_cnt_q  <= digit_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state logic; req_i is only looked at from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (key_stb && last_digit) state_d = ST_DONE;
        else if (expire)           state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the entry datapath.
  always_comb begin
    entry_d      = entry_q;
    data_d       = data_q;
    digit_cnt_d  = digit_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    timeout_d    = 1'b0;
    data_valid_d = (state_d == ST_DONE);
    busy_d       = (state_d == ST_COLLECT);
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          entry_d     = '0;
          digit_cnt_d = '0;
          idle_cnt_d  = '0;
        end
      end
      ST_COLLECT: begin
        if (key_stb) begin
          entry_d     = entry_shift;
          digit_cnt_d = (digit_cnt_q == MAX_CNT) ? digit_cnt_q : digit_cnt_q + 4'd1;
          idle_cnt_d  = '0;
          if (last_digit) data_d = entry_shift;
        end else if (expire) begin
          timeout_d   = 1'b1;
          entry_d     = '0;
          digit_cnt_d = '0;
          idle_cnt_d  = '0;
        end else if ((TIMEOUT_CYC > 0) && (idle_cnt_q != TO_LIMIT)) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign busy_o       = busy_q;
  assign digit_cnt_o  = digit_cnt_q;
  assign entry_o      = entry_q;
  assign timeout_o    = timeout_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl: a vector table for the main sequence plus hand sequences
// for held keys, the inactivity timeout and back-to-back words.
module tb_key_entry_ctrl;
  import key_pkg::*;

  logic       clk;
  logic       rst;
  logic       kv;
  logic [3:0] num;
  logic       req;
  logic       ack;

  // DIGITS=4, no timeout
  logic [15:0] a_data, a_entry;
  logic        a_dv, a_busy, a_to;
  logic [3:0]  a_cnt;
  logic [1:0]  a_st;
  // DIGITS=4, TIMEOUT_CYC=16
  logic [15:0] t_data, t_entry;
  logic        t_dv, t_busy, t_to;
  logic [3:0]  t_cnt;
  logic [1:0]  t_st;
  // DIGITS=2, no timeout
  logic [7:0]  b_data, b_entry;
  logic        b_dv, b_busy, b_to;
  logic [3:0]  b_cnt;
  logic [1:0]  b_st;

  int checks = 0;
  int errors = 0;

  key_entry_ctrl #(.DIGITS(4), .TIMEOUT_CYC(0)) u_def (
    .clk_i(clk), .rst_i(rst), .key_valid_i(kv), .key_num_i(num), .req_i(req), .ack_i(ack),
    .data_o(a_data), .data_valid_o(a_dv), .busy_o(a_busy), .digit_cnt_o(a_cnt),
    .entry_o(a_entry), .timeout_o(a_to), .state_o(a_st)
  );

  key_entry_ctrl #(.DIGITS(4), .TIMEOUT_CYC(16)) u_to (
    .clk_i(clk), .rst_i(rst), .key_valid_i(kv), .key_num_i(num), .req_i(req), .ack_i(ack),
    .data_o(t_data), .data_valid_o(t_dv), .busy_o(t_busy), .digit_cnt_o(t_cnt),
    .entry_o(t_entry), .timeout_o(t_to), .state_o(t_st)
  );

  key_entry_ctrl #(.DIGITS(2), .TIMEOUT_CYC(0)) u_b2b (
    .clk_i(clk), .rst_i(rst), .key_valid_i(kv), .key_num_i(num), .req_i(req), .ack_i(ack),
    .data_o(b_data), .data_valid_o(b_dv), .busy_o(b_busy), .digit_cnt_o(b_cnt),
    .entry_o(b_entry), .timeout_o(b_to), .state_o(b_st)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; kv = 1'b0; num = 4'h0; req = 1'b0; ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: one isolated key press sampled at the next edge, then released (no tick after release).
  task automatic press(input logic [3:0] n);
    kv = 1'b1; num = n;
    tick();
    kv = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        kv;
    logic [3:0]  num;
    logic        req;
    logic        ack;
    logic [1:0]  st;
    logic        dv;
    logic        busy;
    logic [3:0]  cnt;
    logic [15:0] entry;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic r, logic k, logic [3:0] n, logic q, logic a,
                              logic [1:0] s, logic d, logic b, logic [3:0] c,
                              logic [15:0] e, logic [15:0] w);
    vec_t v;
    v.rst = r; v.kv = k; v.num = n; v.req = q; v.ack = a;
    v.st = s; v.dv = d; v.busy = b; v.cnt = c; v.entry = e; v.data = w;
    return v;
  endfunction

  initial begin
    rst = 1'b1; kv = 1'b1; num = 4'h0; req = 1'b1; ack = 1'b0;

    //               rst   kv    num   req   ack   state       dv    busy  cnt   entry    data
    vecs[0]  = mk(1'b1, 1'b1, 4'h0, 1'b1, 1'b0, ST_IDLE,    1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);
    vecs[1]  = mk(1'b1, 1'b1, 4'h0, 1'b1, 1'b0, ST_IDLE,    1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);
    vecs[2]  = mk(1'b0, 1'b1, 4'h5, 1'b0, 1'b0, ST_IDLE,    1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);
    vecs[3]  = mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, ST_COLLECT, 1'b0, 1'b1, 4'd0, 16'h0000, 16'h0000);
    vecs[4]  = mk(1'b0, 1'b1, 4'h1, 1'b1, 1'b0, ST_COLLECT, 1'b0, 1'b1, 4'd1, 16'h0001, 16'h0000);
    vecs[5]  = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, ST_COLLECT, 1'b0, 1'b1, 4'd1, 16'h0001, 16'h0000);
    vecs[6]  = mk(1'b0, 1'b1, 4'hA, 1'b0, 1'b0, ST_COLLECT, 1'b0, 1'b1, 4'd2, 16'h001A, 16'h0000);
    vecs[7]  = mk(1'b0, 1'b1, 4'hA, 1'b0, 1'b0, ST_COLLECT, 1'b0, 1'b1, 4'd2, 16'h001A, 16'h0000);
    vecs[8]  = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, ST_COLLECT, 1'b0, 1'b1, 4'd2, 16'h001A, 16'h0000);
    vecs[9]  = mk(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, ST_COLLECT, 1'b0, 1'b1, 4'd3, 16'h01A3, 16'h0000);
    vecs[10] = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, ST_COLLECT, 1'b0, 1'b1, 4'd3, 16'h01A3, 16'h0000);
    vecs[11] = mk(1'b0, 1'b1, 4'hF, 1'b0, 1'b0, ST_DONE,    1'b1, 1'b0, 4'd4, 16'h1A3F, 16'h1A3F);
    vecs[12] = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, ST_DONE,    1'b1, 1'b0, 4'd4, 16'h1A3F, 16'h1A3F);
    vecs[13] = mk(1'b0, 1'b1, 4'h9, 1'b0, 1'b0, ST_DONE,    1'b1, 1'b0, 4'd4, 16'h1A3F, 16'h1A3F);
    vecs[14] = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, ST_IDLE,    1'b0, 1'b0, 4'd4, 16'h1A3F, 16'h1A3F);
    vecs[15] = mk(1'b0, 1'b1, 4'h2, 1'b0, 1'b0, ST_IDLE,    1'b0, 1'b0, 4'd4, 16'h1A3F, 16'h1A3F);
    vecs[16] = mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, ST_COLLECT, 1'b0, 1'b1, 4'd0, 16'h0000, 16'h1A3F);
    vecs[17] = mk(1'b0, 1'b1, 4'hC, 1'b0, 1'b0, ST_COLLECT, 1'b0, 1'b1, 4'd1, 16'h000C, 16'h1A3F);
    vecs[18] = mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, ST_IDLE,    1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);

    // Reset, nominal word, strobes in IDLE/DONE, reset mid-entry
    for (int i = 0; i < 19; i++) begin
      rst = vecs[i].rst; kv = vecs[i].kv; num = vecs[i].num;
      req = vecs[i].req; ack = vecs[i].ack;
      tick();
      chk($sformatf("vec%0d state", i), {30'd0, a_st}, {30'd0, vecs[i].st});
      chk($sformatf("vec%0d data_valid", i), {31'd0, a_dv}, {31'd0, vecs[i].dv});
      chk($sformatf("vec%0d busy", i), {31'd0, a_busy}, {31'd0, vecs[i].busy});
      chk($sformatf("vec%0d digit_cnt", i), {28'd0, a_cnt}, {28'd0, vecs[i].cnt});
      chk($sformatf("vec%0d entry", i), {16'd0, a_entry}, {16'd0, vecs[i].entry});
      chk($sformatf("vec%0d data", i), {16'd0, a_data}, {16'd0, vecs[i].data});
      chk($sformatf("vec%0d timeout", i), {31'd0, a_to}, 32'd0);
    end

    // Held key counts once
    do_reset();
    req = 1'b1;
    tick();
    req = 1'b0; kv = 1'b1; num = 4'h7;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("held digit_cnt", {28'd0, a_cnt}, 32'd1);
    end
    kv = 1'b0;
    tick();
    chk("held entry", {16'd0, a_entry}, 32'h0007);
    chk("held digit_cnt after release", {28'd0, a_cnt}, 32'd1);
    chk("held busy", {31'd0, a_busy}, 32'd1);

    // Timeout after 16 silent cycles
    do_reset();
    req = 1'b1;
    tick();
    req = 1'b0;
    press(4'h2);
    tick();
    press(4'h8);
    chk("to entry before silence", {16'd0, t_entry}, 32'h0028);
    chk("to digit_cnt before silence", {28'd0, t_cnt}, 32'd2);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("to silent%0d timeout", k), {31'd0, t_to}, 32'd0);
      chk($sformatf("to silent%0d busy", k), {31'd0, t_busy}, 32'd1);
      chk($sformatf("to silent%0d data_valid", k), {31'd0, t_dv}, 32'd0);
    end
    tick();
    chk("to pulse", {31'd0, t_to}, 32'd1);
    chk("to state", {30'd0, t_st}, {30'd0, ST_IDLE});
    chk("to digit_cnt", {28'd0, t_cnt}, 32'd0);
    chk("to entry", {16'd0, t_entry}, 32'd0);
    chk("to busy", {31'd0, t_busy}, 32'd0);
    chk("to data_valid", {31'd0, t_dv}, 32'd0);
    tick();
    chk("to pulse width", {31'd0, t_to}, 32'd0);
    chk("to stays idle", {30'd0, t_st}, {30'd0, ST_IDLE});

    // Strobe on the expiring cycle wins
    do_reset();
    req = 1'b1;
    tick();
    req = 1'b0;
    press(4'h3);
    tick();
    press(4'h4);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("win silent%0d timeout", k), {31'd0, t_to}, 32'd0);
    end
    press(4'h6);
    chk("win timeout", {31'd0, t_to}, 32'd0);
    chk("win busy", {31'd0, t_busy}, 32'd1);
    chk("win digit_cnt", {28'd0, t_cnt}, 32'd3);
    chk("win entry", {16'd0, t_entry}, 32'h0346);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("win2 silent%0d timeout", k), {31'd0, t_to}, 32'd0);
    end
    tick();
    chk("win2 pulse", {31'd0, t_to}, 32'd1);
    chk("win2 state", {30'd0, t_st}, {30'd0, ST_IDLE});

    // Back-to-back words, DIGITS=2, req held high
    do_reset();
    req = 1'b1;
    tick();
    chk("b2b enter collect", {30'd0, b_st}, {30'd0, ST_COLLECT});
    press(4'h5);
    chk("b2b entry1", {24'd0, b_entry}, 32'h05);
    chk("b2b cnt1", {28'd0, b_cnt}, 32'd1);
    tick();
    press(4'h6);
    chk("b2b done", {30'd0, b_st}, {30'd0, ST_DONE});
    chk("b2b dv", {31'd0, b_dv}, 32'd1);
    chk("b2b data1", {24'd0, b_data}, 32'h56);
    tick();
    chk("b2b hold dv", {31'd0, b_dv}, 32'd1);
    ack = 1'b1;
    tick();
    chk("b2b ack idle", {30'd0, b_st}, {30'd0, ST_IDLE});
    chk("b2b ack dv", {31'd0, b_dv}, 32'd0);
    chk("b2b ack data kept", {24'd0, b_data}, 32'h56);
    ack = 1'b0;
    tick();
    chk("b2b restart", {30'd0, b_st}, {30'd0, ST_COLLECT});
    chk("b2b restart entry", {24'd0, b_entry}, 32'h00);
    chk("b2b restart cnt", {28'd0, b_cnt}, 32'd0);
    chk("b2b restart busy", {31'd0, b_busy}, 32'd1);
    press(4'h9);
    tick();
    press(4'hB);
    chk("b2b data2", {24'd0, b_data}, 32'h9B);
    chk("b2b dv2", {31'd0, b_dv}, 32'd1);
    chk("b2b timeout", {31'd0, b_to}, 32'd0);
    ack = 1'b1; req = 1'b0;
    tick();
    ack = 1'b0;
    tick();
    chk("b2b final idle", {30'd0, b_st}, {30'd0, ST_IDLE});
    chk("b2b final dv", {31'd0, b_dv}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
